// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Shares one registered ALU (EN-qualified, result valid one cycle after EN)
//   between NUM_REQ requesters. Requests are accepted round-robin, issued to
//   the ALU, and the result (or a timeout error) is routed back one-hot.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   REQ_VLD/A/B/FUN   packed per-requester request (requester i at slice i)
//   REQ_RDY           one-hot accept pulse
//   ALU_EN/A/B/FUN    ALU operand bus (EN pulses for one cycle per operation)
//   ALU_OUT/VALID     ALU result
//   RSP_VLD           one-hot response pulse
//   RSP_DATA/ERR      response payload, held until the next response
//   BUSY              high whenever the scheduler is not idle
//
// Optional build macro:
//   ALU_SCHED_DIV0_TRAP_EN  answer FUN=4'b0011 with B==0 locally with an
//                           error response, without touching the ALU.
module alu_rr_scheduler #(
    parameter int NUM_REQ  = 2,
    parameter int OPSIZE   = 8,
    parameter int OUT_SIZE = 16,
    parameter int TIMEOUT  = 15
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        REQ_VLD,
    input  logic [NUM_REQ*OPSIZE-1:0] REQ_A,
    input  logic [NUM_REQ*OPSIZE-1:0] REQ_B,
    input  logic [NUM_REQ*4-1:0]      REQ_FUN,
    output logic [NUM_REQ-1:0]        REQ_RDY,
    output logic                      ALU_EN,
    output logic [OPSIZE-1:0]         ALU_A,
    output logic [OPSIZE-1:0]         ALU_B,
    output logic [3:0]                ALU_FUN,
    input  logic [OUT_SIZE-1:0]       ALU_OUT,
    input  logic                      ALU_VALID,
    output logic [NUM_REQ-1:0]        RSP_VLD,
    output logic [OUT_SIZE-1:0]       RSP_DATA,
    output logic                      RSP_ERR,
    output logic                      BUSY
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    req_rdy_q, req_rdy_d;
    logic                  alu_en_q, alu_en_d;
    logic [OPSIZE-1:0]     alu_a_q, alu_a_d;
    logic [OPSIZE-1:0]     alu_b_q, alu_b_d;
    logic [3:0]            alu_fun_q, alu_fun_d;
    logic [NUM_REQ-1:0]    rsp_vld_q, rsp_vld_d;
    logic [OUT_SIZE-1:0]   rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  busy_q, busy_d;

    logic                  found;
    logic [PW-1:0]         gnt;
    int unsigned           idx;
    logic [OPSIZE-1:0]     sel_a, sel_b;
    logic [3:0]            sel_fun;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] k);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (32'(k) == j) v[j] = 1'b1;
        end
        return v;
    endfunction

    // Round-robin search starting just after the last winner.
    always_comb begin
        found = 1'b0;
        gnt   = ptr_q;
        idx   = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && REQ_VLD[PW'(idx)]) begin
                found = 1'b1;
                gnt   = PW'(idx);
            end
        end
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_fun = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (32'(gnt) == j) begin
                sel_a   = REQ_A[j*OPSIZE +: OPSIZE];
                sel_b   = REQ_B[j*OPSIZE +: OPSIZE];
                sel_fun = REQ_FUN[j*4 +: 4];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        req_rdy_d  = '0;
        alu_en_d   = 1'b0;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_fun_d  = alu_fun_q;
        rsp_vld_d  = '0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_rdy_d = onehot(gnt);
                    alu_a_d   = sel_a;
                    alu_b_d   = sel_b;
                    alu_fun_d = sel_fun;
                    ptr_d     = gnt;
                    state_d   = ISSUE;
`ifdef ALU_SCHED_DIV0_TRAP_EN
                    if (sel_fun == 4'b0011 && sel_b == '0) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
`endif
                end
            end
            ISSUE: begin
                alu_en_d = 1'b1;
                cnt_d    = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (ALU_VALID) begin
                    rsp_data_d = ALU_OUT;
                    rsp_err_d  = 1'b0;
                    rsp_vld_d  = onehot(ptr_q);
                    state_d    = RESP;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    rsp_vld_d  = onehot(ptr_q);
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                // Entered from WAIT the pulse is already out; entered
                // straight from IDLE (div0 trap) it is emitted here first.
                if (rsp_vld_q == '0) begin
                    rsp_vld_d = onehot(ptr_q);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            ptr_q      <= PW'(NUM_REQ - 1);
            cnt_q      <= '0;
            req_rdy_q  <= '0;
            alu_en_q   <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_fun_q  <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            req_rdy_q  <= req_rdy_d;
            alu_en_q   <= alu_en_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_fun_q  <= alu_fun_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            busy_q     <= busy_d;
        end
    end

    assign REQ_RDY  = req_rdy_q;
    assign ALU_EN   = alu_en_q;
    assign ALU_A    = alu_a_q;
    assign ALU_B    = alu_b_q;
    assign ALU_FUN  = alu_fun_q;
    assign RSP_VLD  = rsp_vld_q;
    assign RSP_DATA = rsp_data_q;
    assign RSP_ERR  = rsp_err_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural registered ALU.
module tb_alu_rr_scheduler;

    localparam int NUM_REQ  = 2;
    localparam int OPSIZE   = 8;
    localparam int OUT_SIZE = 16;
    localparam int TIMEOUT  = 15;

    logic                      CLK = 1'b0;
    logic                      RST = 1'b1;
    logic [NUM_REQ-1:0]        REQ_VLD = '0;
    logic [NUM_REQ*OPSIZE-1:0] REQ_A = '0;
    logic [NUM_REQ*OPSIZE-1:0] REQ_B = '0;
    logic [NUM_REQ*4-1:0]      REQ_FUN = '0;
    logic [NUM_REQ-1:0]        REQ_RDY;
    logic                      ALU_EN;
    logic [OPSIZE-1:0]         ALU_A;
    logic [OPSIZE-1:0]         ALU_B;
    logic [3:0]                ALU_FUN;
    logic [OUT_SIZE-1:0]       ALU_OUT = '0;
    logic                      ALU_VALID = 1'b0;
    logic [NUM_REQ-1:0]        RSP_VLD;
    logic [OUT_SIZE-1:0]       RSP_DATA;
    logic                      RSP_ERR;
    logic                      BUSY;

    logic withhold = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   spur;

    alu_rr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .OPSIZE  (OPSIZE),
        .OUT_SIZE(OUT_SIZE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ_VLD  (REQ_VLD),
        .REQ_A    (REQ_A),
        .REQ_B    (REQ_B),
        .REQ_FUN  (REQ_FUN),
        .REQ_RDY  (REQ_RDY),
        .ALU_EN   (ALU_EN),
        .ALU_A    (ALU_A),
        .ALU_B    (ALU_B),
        .ALU_FUN  (ALU_FUN),
        .ALU_OUT  (ALU_OUT),
        .ALU_VALID(ALU_VALID),
        .RSP_VLD  (RSP_VLD),
        .RSP_DATA (RSP_DATA),
        .RSP_ERR  (RSP_ERR),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
        case (f)
            4'b0000: return 16'(a) + 16'(b);
            4'b0001: return 16'(a) - 16'(b);
            4'b0010: return 16'(a) * 16'(b);
            4'b0011: return (b == 8'd0) ? 16'd0 : 16'(a / b);
            default: return 16'd0;
        endcase
    endfunction

    // Registered ALU: result valid one cycle after EN.
    always @(posedge CLK) begin
        ALU_VALID <= ALU_EN && !withhold;
        if (ALU_EN) ALU_OUT <= alu_f(ALU_A, ALU_B, ALU_FUN);
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] f);
        REQ_A[i*OPSIZE +: OPSIZE] = a;
        REQ_B[i*OPSIZE +: OPSIZE] = b;
        REQ_FUN[i*4 +: 4]         = f;
    endtask

    initial begin
        // ---- reset state
        tick;
        tick;
        check("rst_rdy",  32'(REQ_RDY), 0);
        check("rst_en",   32'(ALU_EN), 0);
        check("rst_vld",  32'(RSP_VLD), 0);
        check("rst_data", 32'(RSP_DATA), 0);
        check("rst_err",  32'(RSP_ERR), 0);
        check("rst_busy", 32'(BUSY), 0);

        // ---- single request: 12 + 5
        RST = 1'b0;
        set_req(0, 8'd12, 8'd5, 4'b0000);
        REQ_VLD = 2'b01;
        tick;                                   // t
        check("s_rdy",  32'(REQ_RDY), 1);
        check("s_busy", 32'(BUSY), 1);
        check("s_en_t", 32'(ALU_EN), 0);
        check("s_a",    32'(ALU_A), 12);
        REQ_VLD = 2'b00;
        tick;                                   // t+1
        check("s_en",   32'(ALU_EN), 1);
        check("s_b",    32'(ALU_B), 5);
        check("s_rdy1", 32'(REQ_RDY), 0);
        tick;                                   // t+2
        check("s_en2",  32'(ALU_EN), 0);
        check("s_vld2", 32'(RSP_VLD), 0);
        tick;                                   // t+3
        check("s_rsp",  32'(RSP_VLD), 1);
        check("s_data", 32'(RSP_DATA), 17);
        check("s_err",  32'(RSP_ERR), 0);
        tick;                                   // t+4
        check("s_rsp_end", 32'(RSP_VLD), 0);
        check("s_idle",    32'(BUSY), 0);
        check("s_hold",    32'(RSP_DATA), 17);

        // ---- round robin after reset: 3*4 and 7*9
        RST = 1'b1;
        tick;
        RST = 1'b0;
        set_req(0, 8'd3, 8'd4, 4'b0010);
        set_req(1, 8'd7, 8'd9, 4'b0010);
        REQ_VLD = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("rr_rdy", 32'(REQ_RDY), (k % 2 == 0) ? 1 : 2);
            check("rr_a",   32'(ALU_A),   (k % 2 == 0) ? 3 : 7);
            tick;
            tick;
            tick;
            check("rr_rsp",  32'(RSP_VLD),  (k % 2 == 0) ? 1 : 2);
            check("rr_data", 32'(RSP_DATA), (k % 2 == 0) ? 12 : 63);
            check("rr_err",  32'(RSP_ERR), 0);
            tick;
        end
        REQ_VLD = 2'b00;
        tick;

        // ---- timeout: ALU never answers
        withhold = 1'b1;
        set_req(0, 8'd1, 8'd1, 4'b0000);
        REQ_VLD = 2'b01;
        tick;                                   // t
        check("to_rdy", 32'(REQ_RDY), 1);
        REQ_VLD = 2'b00;
        tick;                                   // t+1, first WAIT cycle
        check("to_en", 32'(ALU_EN), 1);
        spur = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (RSP_VLD != 2'b00) spur++;
        end
        check("to_early", 32'(spur), 0);
        tick;                                   // 16 cycles into WAIT
        check("to_rsp",  32'(RSP_VLD), 1);
        check("to_data", 32'(RSP_DATA), 0);
        check("to_err",  32'(RSP_ERR), 1);
        withhold = 1'b0;
        tick;
        check("to_idle", 32'(BUSY), 0);
        set_req(1, 8'd200, 8'd100, 4'b0000);
        REQ_VLD = 2'b10;
        tick;
        check("to_next_rdy", 32'(REQ_RDY), 2);
        REQ_VLD = 2'b00;
        tick;
        tick;
        tick;
        check("to_next_rsp",  32'(RSP_VLD), 2);
        check("to_next_data", 32'(RSP_DATA), 300);
        check("to_next_err",  32'(RSP_ERR), 0);
        tick;

        // ---- reset during WAIT
        set_req(0, 8'd3, 8'd4, 4'b0010);
        REQ_VLD = 2'b01;
        tick;
        check("rw_rdy", 32'(REQ_RDY), 1);
        REQ_VLD = 2'b00;
        tick;
        check("rw_en", 32'(ALU_EN), 1);
        RST = 1'b1;
        tick;
        check("rw_en0",   32'(ALU_EN), 0);
        check("rw_a0",    32'(ALU_A), 0);
        check("rw_b0",    32'(ALU_B), 0);
        check("rw_fun0",  32'(ALU_FUN), 0);
        check("rw_data0", 32'(RSP_DATA), 0);
        check("rw_busy0", 32'(BUSY), 0);
        check("rw_vld0",  32'(RSP_VLD), 0);
        RST = 1'b0;
        spur = 0;
        for (int i = 0; i < 4; i++) begin
            if (RSP_VLD != 2'b00 || BUSY) spur++;
            tick;
        end
        check("rw_quiet", 32'(spur), 0);
        set_req(1, 8'd7, 8'd9, 4'b0010);
        REQ_VLD = 2'b11;
        tick;
        check("rw_gnt0", 32'(REQ_RDY), 1);
        REQ_VLD = 2'b00;
        tick;
        tick;
        tick;
        check("rw_rsp",  32'(RSP_VLD), 1);
        check("rw_data", 32'(RSP_DATA), 12);
        tick;

        // ---- divide by zero
        set_req(0, 8'd20, 8'd0, 4'b0011);
        REQ_VLD = 2'b01;
        tick;                                   // t
        check("dz_rdy", 32'(REQ_RDY), 1);
        REQ_VLD = 2'b00;
`ifdef ALU_SCHED_DIV0_TRAP_EN
        check("dz_en_t", 32'(ALU_EN), 0);
        tick;                                   // t+1
        check("dz_rsp",  32'(RSP_VLD), 1);
        check("dz_data", 32'(RSP_DATA), 0);
        check("dz_err",  32'(RSP_ERR), 1);
        check("dz_en_t1", 32'(ALU_EN), 0);
        tick;                                   // t+2
        check("dz_en_t2", 32'(ALU_EN), 0);
        check("dz_idle",  32'(BUSY), 0);
`else
        tick;                                   // t+1
        check("dz_en", 32'(ALU_EN), 1);
        tick;
        tick;                                   // t+3
        check("dz_rsp",  32'(RSP_VLD), 1);
        check("dz_data", 32'(RSP_DATA), 0);
        check("dz_err",  32'(RSP_ERR), 0);
        tick;
`endif

        // ---- req1 pulses REQ_VLD while busy serving req0: 50 - 6
        set_req(0, 8'd50, 8'd6, 4'b0001);
        set_req(1, 8'd9, 8'd9, 4'b0000);
        REQ_VLD = 2'b01;
        tick;                                   // t
        check("bz_rdy", 32'(REQ_RDY), 1);
        REQ_VLD = 2'b10;
        spur = 0;
        tick;                                   // t+1
        if (REQ_RDY != 2'b00 || RSP_VLD != 2'b00) spur++;
        REQ_VLD = 2'b00;
        tick;                                   // t+2
        if (REQ_RDY != 2'b00 || RSP_VLD != 2'b00) spur++;
        tick;                                   // t+3
        check("bz_rsp",  32'(RSP_VLD), 1);
        check("bz_data", 32'(RSP_DATA), 44);
        check("bz_rdy3", 32'(REQ_RDY), 0);
        for (int i = 0; i < 8; i++) begin
            tick;
            if (REQ_RDY != 2'b00 || RSP_VLD != 2'b00) spur++;
        end
        check("bz_spurious", 32'(spur), 0);
        check("bz_idle", 32'(BUSY), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
